// File: rtl/control_unit_pkg.sv
// Shared types and mux-select encodings for control_unit and data_path.
package control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_operation_t;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, WB, MEM_RD, LD_WB, MEM_WR, JUMP, HALT
    } ctrl_state_t;

    localparam logic [1:0] SEL1_RD2  = 2'd0;
    localparam logic [1:0] SEL1_IMM4 = 2'd1;
    localparam logic [1:0] SEL1_ONE  = 2'd2;
    localparam logic [1:0] SEL1_ZERO = 2'd3;

    localparam logic [1:0] SEL2_IMM2 = 2'd0;
    localparam logic [1:0] SEL2_PC   = 2'd1;
    localparam logic [1:0] SEL2_RD1  = 2'd2;
    localparam logic [1:0] SEL2_ZERO = 2'd3;

    localparam logic [1:0] RES_MEM    = 2'd0;
    localparam logic [1:0] RES_ALUOUT = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;

    localparam logic ADDR_SRC = 1'b0;
    localparam logic ADDR_DST = 1'b1;

    typedef struct packed {
        logic           ir_write;
        logic           pc_write;
        logic           reg_write;
        logic           mem_write;
        logic           alu_write;
        logic           zero_write;
        logic [1:0]     alu_sel1;
        logic [1:0]     alu_sel2;
        alu_operation_t alu_op;
        logic           addr_sel;
        logic [1:0]     result_sel;
        logic           halted;
        logic           busy;
    } ctrl_bundle_t;

    function automatic alu_operation_t alu_op_for(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Pure combinational map from (state, opcode) to the data_path control bundle.
module control_decoder
    import control_unit_pkg::*;
(
    input  ctrl_state_t  state,
    input  opcode_t      opcode,
    output ctrl_bundle_t ctl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        ctl        = '0;
        ctl.alu_op = ALU_ADD;
        ctl.busy   = (state != IDLE) && (state != HALT);
        case (state)
            FETCH: begin
                ctl.ir_write   = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.alu_sel1   = SEL1_ONE;
                ctl.alu_sel2   = SEL2_PC;
                ctl.result_sel = RES_ALURES;
            end
            EXEC: begin
                ctl.alu_sel1   = SEL1_RD2;
                ctl.alu_sel2   = (opcode == OP_ADDI) ? SEL2_IMM2 : SEL2_RD1;
                ctl.alu_op     = alu_op_for(opcode);
                ctl.alu_write  = 1'b1;
                ctl.zero_write = 1'b1;
            end
            WB: begin
                ctl.result_sel = RES_ALUOUT;
                ctl.reg_write  = 1'b1;
            end
            MEM_RD: ctl.addr_sel = ADDR_SRC;
            LD_WB: begin
                ctl.addr_sel   = ADDR_SRC;
                ctl.result_sel = RES_MEM;
                ctl.reg_write  = 1'b1;
            end
            MEM_WR: begin
                ctl.addr_sel  = ADDR_SRC;
                ctl.mem_write = 1'b1;
            end
            JUMP: begin
                ctl.alu_sel1   = SEL1_IMM4;
                ctl.alu_sel2   = SEL2_ZERO;
                ctl.result_sel = RES_ALURES;
                ctl.pc_write   = 1'b1;
            end
            HALT:    ctl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle controller: state register, next-state logic and a saturating
// retired-instruction counter; control outputs come from control_decoder.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  opcode_t                opcode,
    input  logic                   zero,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic                   mem_write,
    output logic                   alu_write,
    output logic                   zero_write,
    output logic [1:0]             alu_sel1,
    output logic [1:0]             alu_sel2,
    output alu_operation_t         alu_op,
    output logic                   addr_sel,
    output logic [1:0]             result_sel,
    output logic                   halted,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] retired
);

    ctrl_state_t            state_q, state_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   retire;
    ctrl_bundle_t           ctl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = EXEC;
                    OP_LD:  state_d = MEM_RD;
                    OP_ST:  state_d = MEM_WR;
                    OP_JMP: state_d = JUMP;
                    OP_JZ: begin
                        if (zero) begin
                            state_d = JUMP;
                        end else begin
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        state_d = HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            EXEC:   state_d = WB;
            MEM_RD: state_d = LD_WB;
            WB, LD_WB, MEM_WR, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Saturate at all-ones so long programs never wrap the count.
        retired_d = (retire && (retired_q != '1)) ? retired_q + COUNT_WIDTH'(1) : retired_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    control_decoder u_decoder (
        .state  (state_q),
        .opcode (opcode),
        .ctl    (ctl)
    );

    assign ir_write   = ctl.ir_write;
    assign pc_write   = ctl.pc_write;
    assign reg_write  = ctl.reg_write;
    assign mem_write  = ctl.mem_write;
    assign alu_write  = ctl.alu_write;
    assign zero_write = ctl.zero_write;
    assign alu_sel1   = ctl.alu_sel1;
    assign alu_sel2   = ctl.alu_sel2;
    assign alu_op     = ctl.alu_op;
    assign addr_sel   = ctl.addr_sel;
    assign result_sel = ctl.result_sel;
    assign halted     = ctl.halted;
    assign busy       = ctl.busy;
    assign retired    = retired_q;

endmodule
